// File: rtl/sysid_reader.sv
// sysid_reader: reads the ID and timestamp words over Avalon-MM and checks them against expected values.
// Optional SYSID_READER_TIMEOUT_EN adds a per-read cycle timeout that sets timeout_err.
module sysid_reader #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'h500D1B92,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err
);
   typedef enum logic [2:0] {IDLE, CMD_ID, RSP_ID, CMD_TS, RSP_TS, FIN} state_t;
   state_t r_state, w_next;
   logic w_cmd, w_rsp, w_accept, w_cap_id, w_cap_ts, w_to, w_go;
   logic [31:0] r_id_value, r_ts_value;
   logic r_id_ok, r_ts_ok;
   assign w_cmd    = (r_state == CMD_ID) || (r_state == CMD_TS);
   assign w_rsp    = (r_state == RSP_ID) || (r_state == RSP_TS);
   assign w_accept = w_cmd && !avm_waitrequest;
   assign w_go     = (r_state == IDLE) && start;
   // data may arrive in the accept cycle itself, so capture in CMD_* as well as RSP_*
   assign w_cap_id = !w_to && avm_readdatavalid && ((r_state == CMD_ID && w_accept) || r_state == RSP_ID);
   assign w_cap_ts = !w_to && avm_readdatavalid && ((r_state == CMD_TS && w_accept) || r_state == RSP_TS);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? CMD_ID : IDLE;
         CMD_ID:  w_next = !w_accept ? CMD_ID : avm_readdatavalid ? CMD_TS : RSP_ID;
         RSP_ID:  w_next = avm_readdatavalid ? CMD_TS : RSP_ID;
         CMD_TS:  w_next = !w_accept ? CMD_TS : avm_readdatavalid ? FIN : RSP_TS;
         RSP_TS:  w_next = avm_readdatavalid ? FIN : RSP_TS;
         default: w_next = IDLE;
      endcase
      if (w_to) w_next = FIN;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_id_value <= '0;
         r_ts_value <= '0;
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_go) begin
            r_id_ok <= 1'b0;
            r_ts_ok <= 1'b0;
         end
         if (w_cap_id) begin
            r_id_value <= avm_readdata;
            r_id_ok    <= (avm_readdata == EXPECTED_ID);
         end
         if (w_cap_ts) begin
            r_ts_value <= avm_readdata;
            r_ts_ok    <= (avm_readdata == EXPECTED_TS);
         end
      end
   end
`ifdef SYSID_READER_TIMEOUT_EN
   logic [7:0] r_cnt;
   logic       r_timeout_err;
   assign w_to = (w_cmd || w_rsp) && (r_cnt >= 8'(TIMEOUT_CYCLES));
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_go ? 1'b0 : (w_to ? 1'b1 : r_timeout_err);
         r_cnt         <= ((w_next == CMD_ID || w_next == CMD_TS) && w_next != r_state) ? 8'd0 :
                          (w_cmd || w_rsp) ? r_cnt + 8'd1 : r_cnt;
      end
   end
   assign timeout_err = r_timeout_err;
`else
   assign w_to        = 1'b0;
   assign timeout_err = 1'b0;
`endif
   assign avm_read    = w_cmd;
   assign avm_address = (r_state == CMD_TS) || (r_state == RSP_TS);
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == FIN);
   assign id_value    = r_id_value;
   assign ts_value    = r_ts_value;
   assign id_ok       = r_id_ok;
   assign ts_ok       = r_ts_ok;
endmodule

// File: tb/tb_sysid_reader.sv
// tb_sysid_reader: directed self-checking bench for sysid_reader driving a hand-scripted Avalon-MM slave.
module tb_sysid_reader;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address, avm_read;
   logic        avm_waitrequest = 1'b0;
   logic        avm_readdatavalid = 1'b0;
   logic [31:0] avm_readdata = '0;
   logic        busy, done, id_ok, ts_ok, timeout_err;
   logic [31:0] id_value, ts_value;
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   sysid_reader #(.TIMEOUT_CYCLES(10)) dut (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata(avm_readdata), .busy(busy), .done(done),
      .id_value(id_value), .ts_value(ts_value),
      .id_ok(id_ok), .ts_ok(ts_ok), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Slave side of one read: ws stall cycles, then data either with the accept or one cycle after.
   task automatic do_read(input int ws, input bit same, input logic [31:0] d, input logic a);
      avm_waitrequest = 1'b1;
      repeat (ws) begin
         chk("stall_read", avm_read, 1'b1);
         chk("stall_addr", avm_address, a);
         tick();
      end
      avm_waitrequest = 1'b0;
      chk("cmd_read", avm_read, 1'b1);
      chk("cmd_addr", avm_address, a);
      if (same) begin
         avm_readdatavalid = 1'b1;
         avm_readdata = d;
      end
      tick();
      avm_readdatavalid = 1'b0;
      if (!same) begin
         chk("rsp_read", avm_read, 1'b0);
         chk("rsp_addr", avm_address, a);
         avm_readdatavalid = 1'b1;
         avm_readdata = d;
         tick();
         avm_readdatavalid = 1'b0;
      end
   endtask

   task automatic run(input int ws, input bit same, input logic [31:0] id, input logic [31:0] ts,
                      input int exp_cyc, input logic eid, input logic ets);
      start = 1'b1;
      cyc = 0;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1'b1);
      chk("start_id_ok_clr", id_ok, 1'b0);
      chk("start_ts_ok_clr", ts_ok, 1'b0);
      do_read(ws, same, id, 1'b0);
      do_read(ws, same, ts, 1'b1);
      chk("fin_cycles", cyc, exp_cyc);
      chk("fin_done", done, 1'b1);
      chk("fin_id_value", id_value, id);
      chk("fin_ts_value", ts_value, ts);
      chk("fin_id_ok", id_ok, eid);
      chk("fin_ts_ok", ts_ok, ets);
      chk("fin_terr", timeout_err, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_done", done, 1'b0);
      chk("post_busy", busy, 1'b0);
      chk("post_id_ok_hold", id_ok, eid);
      chk("post_ts_ok_hold", ts_ok, ets);
   endtask

   initial begin
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_read", avm_read, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_id_value", id_value, 32'h0);
      chk("rst_ts_ok", ts_ok, 1'b0);
      run(0, 1'b0, 32'h0, 32'h500D1B92, 5, 1'b1, 1'b1);
      run(3, 1'b0, 32'h0, 32'h500D1B92, 11, 1'b1, 1'b1);
      run(0, 1'b0, 32'h0, 32'h12345678, 5, 1'b1, 1'b0);
      run(0, 1'b1, 32'h0, 32'h500D1B92, 3, 1'b1, 1'b1);
      avm_readdatavalid = 1'b1;
      avm_readdata = 32'hDEADBEEF;
      tick();
      avm_readdatavalid = 1'b0;
      chk("idle_rdv_busy", busy, 1'b0);
      chk("idle_rdv_id_value", id_value, 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("noresp_rsp_read", avm_read, 1'b0);
`ifdef SYSID_READER_TIMEOUT_EN
      for (int i = 0; i < 40 && !done; i++) tick();
      chk("to_done", done, 1'b1);
      chk("to_terr", timeout_err, 1'b1);
      chk("to_id_ok", id_ok, 1'b0);
      chk("to_ts_ok", ts_ok, 1'b0);
      tick();
      chk("to_busy", busy, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("to_terr_clr", timeout_err, 1'b0);
      tick();
`else
      repeat (40) tick();
      chk("noto_busy", busy, 1'b1);
      chk("noto_done", done, 1'b0);
      chk("noto_terr", timeout_err, 1'b0);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_read", avm_read, 1'b0);
      chk("mid_rst_addr", avm_address, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_ts_value", ts_value, 32'h0);
      chk("mid_rst_id_ok", id_ok, 1'b0);
      chk("mid_rst_terr", timeout_err, 1'b0);
      avm_readdatavalid = 1'b1;
      avm_readdata = 32'h500D1B92;
      tick();
      avm_readdatavalid = 1'b0;
      chk("late_rdv_busy", busy, 1'b0);
      chk("late_rdv_ts_value", ts_value, 32'h0);
      chk("late_rdv_id_value", id_value, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
